// File: rtl/lsu_pkg.sv
// ============================================================================
// lsu_pkg : op-code constants, FSM state encoding and size helpers for m_lsu
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package lsu_pkg;

  localparam logic [2:0] OP_FULL = 3'b000;
  localparam logic [2:0] OP_UB   = 3'b001;
  localparam logic [2:0] OP_SB   = 3'b010;
  localparam logic [2:0] OP_UH   = 3'b011;
  localparam logic [2:0] OP_SH   = 3'b100;
  localparam logic [2:0] OP_UW   = 3'b101;
  localparam logic [2:0] OP_SW   = 3'b110;

  localparam int DATA_W_DEFAULT = 32;
  localparam int BE_W           = DATA_W_DEFAULT / 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } lsu_state_e;

  function automatic int be_width(input int data_w);
    return data_w / 8;
  endfunction

  // Access size in bytes; word ops collapse to a full-bus access on a 32-bit bus.
  function automatic logic [3:0] op_size(input logic [2:0] op, input int data_w);
    logic [3:0] full;
    full = 4'(data_w / 8);
    case (op)
      OP_UB, OP_SB: return 4'd1;
      OP_UH, OP_SH: return 4'd2;
      OP_UW, OP_SW: return (data_w == 64) ? 4'd4 : full;
      default:      return full;
    endcase
  endfunction

  function automatic logic op_signed(input logic [2:0] op, input int data_w);
    return (op == OP_SB) || (op == OP_SH) || ((op == OP_SW) && (data_w == 64));
  endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_load_ext.sv
// ============================================================================
// lsu_load_ext : combinational lane select plus sign/zero extension of load data
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_load_ext
  import lsu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0]              rdata,
  input  logic [$clog2(DATA_W/8)-1:0]    offset,
  input  logic [3:0]                     size,
  input  logic                           is_signed,
  output logic [DATA_W-1:0]              ext
);

  localparam int LANES = be_width(DATA_W);

  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] mask;
  logic              msb;

  always_comb begin
    shifted = rdata >> {offset, 3'b000};
    mask    = '0;
    msb     = 1'b0;
    for (int b = 0; b < LANES; b++) begin
      mask[b*8 +: 8] = (b < int'(size)) ? 8'hFF : 8'h00;
      if (b == int'(size) - 1)
        msb = shifted[b*8 + 7];
    end
    ext = (shifted & mask) | ((is_signed && msb) ? ~mask : '0);
  end

endmodule

`default_nettype wire

// File: rtl/m_lsu.sv
// ============================================================================
// m_lsu : memory-stage load/store unit, valid/ready core side, req/ack memory side
// Optional: LSU_ALIGN_CHECK_EN reports misaligned accesses via rsp_err instead
//           of silently aligning them.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module m_lsu
  import lsu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_op,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W/8-1:0]   mem_be,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic                  mem_ack,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err,
  output logic                  busy
);

  localparam int LANES = be_width(DATA_W);
  localparam int OFF_W = $clog2(LANES);

  lsu_state_e        state;
  logic [OFF_W-1:0]  lat_off;
  logic [3:0]        lat_size;
  logic              lat_signed;

  logic [3:0]        size_d;
  logic              signed_d;
  logic [OFF_W-1:0]  low_d;
  logic [OFF_W-1:0]  size_m1;
  logic [OFF_W-1:0]  off_d;
  logic              misaligned;
  logic [LANES-1:0]  be_d;
  logic [DATA_W-1:0] wmask_d;
  logic [DATA_W-1:0] wdata_d;
  logic [DATA_W-1:0] ext_data;

  always_comb begin
    size_d   = op_size(req_op, DATA_W);
    signed_d = op_signed(req_op, DATA_W);
    low_d    = req_addr[OFF_W-1:0];
    size_m1  = OFF_W'(size_d - 4'd1);
`ifdef LSU_ALIGN_CHECK_EN
    misaligned = |(low_d & size_m1);
    off_d      = low_d;
`else
    // Without checking, drop the offset bits below the access size.
    misaligned = 1'b0;
    off_d      = low_d & ~size_m1;
`endif
    be_d    = '0;
    wmask_d = '0;
    for (int b = 0; b < LANES; b++) begin
      be_d[b]          = (b >= int'(off_d)) && (b < int'(off_d) + int'(size_d));
      wmask_d[b*8 +: 8] = (b < int'(size_d)) ? 8'hFF : 8'h00;
    end
    wdata_d = (req_wdata & wmask_d) << {off_d, 3'b000};
  end

  lsu_load_ext #(
    .DATA_W    (DATA_W)
  ) u_load_ext (
    .rdata     (mem_rdata),
    .offset    (lat_off),
    .size      (lat_size),
    .is_signed (lat_signed),
    .ext       (ext_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      req_ready  <= 1'b1;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_be     <= '0;
      mem_wdata  <= '0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
      busy       <= 1'b0;
      lat_off    <= '0;
      lat_size   <= '0;
      lat_signed <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            busy      <= 1'b1;
            if (misaligned) begin
              state     <= ST_RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end else begin
              state      <= ST_ACCESS;
              mem_req    <= 1'b1;
              mem_we     <= req_we;
              mem_addr   <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
              mem_be     <= be_d;
              mem_wdata  <= wdata_d;
              lat_off    <= off_d;
              lat_size   <= size_d;
              lat_signed <= signed_d;
            end
          end
        end
        ST_ACCESS: begin
          if (mem_ack) begin
            state     <= ST_RESP;
            mem_req   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_rdata <= mem_we ? '0 : ext_data;
          end
        end
        ST_RESP: begin
          state     <= ST_IDLE;
          busy      <= 1'b0;
          req_ready <= 1'b1;
          rsp_err   <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_m_lsu.sv
// ============================================================================
// tb_m_lsu : self-checking bench for m_lsu, 32-bit and 64-bit instances
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_m_lsu;

  typedef struct {
    bit          err;
    logic [31:0] addr;
    logic [7:0]  be;
    logic [63:0] wdata;
    logic [63:0] rdata;
  } exp_t;

  typedef struct {
    bit          w64;
    bit          we;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [63:0] rdata;
    int          dly;
    exp_t        e;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        w64 = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [2:0]  req_op = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [63:0] req_wdata = 64'd0;
  logic        mem_ack = 1'b0;
  logic [63:0] mem_rdata = 64'd0;

  logic        ready_32, mreq_32, mwe_32, rvalid_32, rerr_32, busy_32;
  logic [31:0] maddr_32, mwdata_32, rrdata_32;
  logic [3:0]  mbe_32;
  logic        ready_64, mreq_64, mwe_64, rvalid_64, rerr_64, busy_64;
  logic [31:0] maddr_64;
  logic [63:0] mwdata_64, rrdata_64;
  logic [7:0]  mbe_64;

  logic        s_ready, s_mreq, s_mwe, s_rvalid, s_rerr, s_busy;
  logic [31:0] s_maddr;
  logic [7:0]  s_mbe;
  logic [63:0] s_mwdata, s_rrdata;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  m_lsu #(.DATA_W(32), .ADDR_W(32)) dut32 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid & ~w64), .req_ready(ready_32), .req_we(req_we), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata[31:0]),
    .mem_req(mreq_32), .mem_we(mwe_32), .mem_addr(maddr_32), .mem_be(mbe_32),
    .mem_wdata(mwdata_32), .mem_ack(mem_ack & ~w64), .mem_rdata(mem_rdata[31:0]),
    .rsp_valid(rvalid_32), .rsp_rdata(rrdata_32), .rsp_err(rerr_32), .busy(busy_32)
  );

  m_lsu #(.DATA_W(64), .ADDR_W(32)) dut64 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid & w64), .req_ready(ready_64), .req_we(req_we), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_req(mreq_64), .mem_we(mwe_64), .mem_addr(maddr_64), .mem_be(mbe_64),
    .mem_wdata(mwdata_64), .mem_ack(mem_ack & w64), .mem_rdata(mem_rdata),
    .rsp_valid(rvalid_64), .rsp_rdata(rrdata_64), .rsp_err(rerr_64), .busy(busy_64)
  );

  always_comb begin
    s_ready  = w64 ? ready_64  : ready_32;
    s_mreq   = w64 ? mreq_64   : mreq_32;
    s_mwe    = w64 ? mwe_64    : mwe_32;
    s_rvalid = w64 ? rvalid_64 : rvalid_32;
    s_rerr   = w64 ? rerr_64   : rerr_32;
    s_busy   = w64 ? busy_64   : busy_32;
    s_maddr  = w64 ? maddr_64  : maddr_32;
    s_mbe    = w64 ? mbe_64    : {4'h0, mbe_32};
    s_mwdata = w64 ? mwdata_64 : {32'h0, mwdata_32};
    s_rrdata = w64 ? rrdata_64 : {32'h0, rrdata_32};
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: value-level description of what a request must produce.
  function automatic exp_t model(input bit wide, input bit we, input logic [2:0] op,
                                 input logic [31:0] addr, input logic [63:0] wd,
                                 input logic [63:0] rd);
    exp_t        e;
    int          lanes, size, low, off;
    bit          sgn;
    logic [63:0] smask, dmask, v;
    lanes = wide ? 8 : 4;
    case (op)
      3'd1, 3'd2: size = 1;
      3'd3, 3'd4: size = 2;
      3'd5, 3'd6: size = wide ? 4 : lanes;
      default:    size = lanes;
    endcase
    sgn = (op == 3'd2) || (op == 3'd4) || (op == 3'd6 && wide);
    low = int'(addr % lanes);
    e.err = 1'b0;
`ifdef LSU_ALIGN_CHECK_EN
    e.err = (low % size) != 0;
    off = low;
`else
    off = low - (low % size);
`endif
    e.addr = addr - 32'(low);
    smask = (size == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : (64'd1 << (8 * size)) - 64'd1;
    dmask = wide ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    e.be = 8'(((64'd1 << size) - 64'd1) << off);
    e.wdata = ((wd & smask) << (8 * off)) & dmask;
    v = ((rd & dmask) >> (8 * off)) & smask;
    if (sgn && v[8*size-1]) v = (v | ~smask) & dmask;
    e.rdata = we ? 64'd0 : v;
    return e;
  endfunction

  function automatic vec_t mk(input bit wide, input bit we, input logic [2:0] op,
                              input logic [31:0] addr, input logic [63:0] wd,
                              input logic [63:0] rd, input int dly, input bit err,
                              input logic [31:0] eaddr, input logic [7:0] ebe,
                              input logic [63:0] ewd, input logic [63:0] erd);
    vec_t v;
    v.w64 = wide; v.we = we; v.op = op; v.addr = addr; v.wdata = wd; v.rdata = rd; v.dly = dly;
    v.e.err = err; v.e.addr = eaddr; v.e.be = ebe; v.e.wdata = ewd; v.e.rdata = erd;
    return v;
  endfunction

  task automatic run(input vec_t v, input string tag);
    int n;
    w64 = v.w64;
    n = 0;
    #1;
    while (!s_ready && n < 10) begin
      @(posedge clk); #1; n++;
    end
    chk({tag, " ready"}, 64'(s_ready), 64'd1);
    if (!s_ready) return;
    req_we = v.we; req_op = v.op; req_addr = v.addr; req_wdata = v.wdata; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (v.e.err) begin
      chk({tag, " err_valid"}, 64'(s_rvalid), 64'd1);
      chk({tag, " err_flag"}, 64'(s_rerr), 64'd1);
      chk({tag, " err_no_mreq"}, 64'(s_mreq), 64'd0);
      @(posedge clk); #1;
      chk({tag, " err_pulse"}, 64'(s_rvalid), 64'd0);
      chk({tag, " err_mreq_after"}, 64'(s_mreq), 64'd0);
      return;
    end
    chk({tag, " mreq"}, 64'(s_mreq), 64'd1);
    chk({tag, " busy"}, 64'(s_busy), 64'd1);
    chk({tag, " mwe"}, 64'(s_mwe), 64'(v.we));
    chk({tag, " maddr"}, 64'(s_maddr), 64'(v.e.addr));
    if (v.we) begin
      chk({tag, " mbe"}, 64'(s_mbe), 64'(v.e.be));
      chk({tag, " mwdata"}, s_mwdata, v.e.wdata);
    end
    for (int d = 0; d < v.dly; d++) begin
      @(posedge clk); #1;
      chk({tag, " mreq_hold"}, 64'(s_mreq), 64'd1);
      chk({tag, " busy_hold"}, 64'(s_busy), 64'd1);
      chk({tag, " no_early_rsp"}, 64'(s_rvalid), 64'd0);
    end
    mem_ack = 1'b1; mem_rdata = v.rdata;
    @(posedge clk); #1;
    mem_ack = 1'b0; mem_rdata = {$urandom, $urandom};
    chk({tag, " rsp_valid"}, 64'(s_rvalid), 64'd1);
    chk({tag, " rsp_err"}, 64'(s_rerr), 64'd0);
    chk({tag, " rsp_rdata"}, s_rrdata, v.e.rdata);
    chk({tag, " mreq_drop"}, 64'(s_mreq), 64'd0);
    @(posedge clk); #1;
    chk({tag, " rsp_pulse"}, 64'(s_rvalid), 64'd0);
    chk({tag, " idle_ready"}, 64'(s_ready), 64'd1);
    chk({tag, " idle_busy"}, 64'(s_busy), 64'd0);
  endtask

  vec_t tbl[$];

  initial begin
    vec_t v;
    bit   ck;
`ifdef LSU_ALIGN_CHECK_EN
    ck = 1'b1;
`else
    ck = 1'b0;
`endif
    tbl.push_back(mk(0, 0, 3'd2, 32'h1003, 64'h0, 64'h80FF_1234, 0, 0, 32'h1000, 8'h0, 64'h0, 64'hFFFF_FF80));
    tbl.push_back(mk(0, 0, 3'd3, 32'h2002, 64'h0, 64'hABCD_0001, 4, 0, 32'h2000, 8'h0, 64'h0, 64'h0000_ABCD));
    tbl.push_back(mk(0, 1, 3'd2, 32'h3001, 64'hA5, 64'h0, 1, 0, 32'h3000, 8'h2, 64'hA500, 64'h0));
    tbl.push_back(mk(0, 0, 3'd4, 32'h4001, 64'h0, 64'h1234_8765, 0, ck, 32'h4000, 8'h0, 64'h0, 64'hFFFF_8765));
    tbl.push_back(mk(0, 0, 3'd0, 32'h5000, 64'h0, 64'hDEAD_BEEF, 1, 0, 32'h5000, 8'h0, 64'h0, 64'hDEAD_BEEF));
    tbl.push_back(mk(0, 0, 3'd1, 32'h6002, 64'h0, 64'h00C3_0000, 0, 0, 32'h6000, 8'h0, 64'h0, 64'hC3));
    tbl.push_back(mk(0, 1, 3'd4, 32'h7002, 64'hFFFF_1234, 64'h0, 2, 0, 32'h7000, 8'hC, 64'h1234_0000, 64'h0));
    tbl.push_back(mk(0, 1, 3'd0, 32'h8000, 64'hCAFE_F00D, 64'h0, 0, 0, 32'h8000, 8'hF, 64'hCAFE_F00D, 64'h0));
    tbl.push_back(mk(0, 0, 3'd6, 32'h9000, 64'h0, 64'h8000_0001, 0, 0, 32'h9000, 8'h0, 64'h0, 64'h8000_0001));
    tbl.push_back(mk(0, 0, 3'd7, 32'hA004, 64'h0, 64'hFFFF_FFFE, 0, 0, 32'hA004, 8'h0, 64'h0, 64'hFFFF_FFFE));
    tbl.push_back(mk(0, 1, 3'd1, 32'hB003, 64'h1FF, 64'h0, 0, 0, 32'hB000, 8'h8, 64'hFF00_0000, 64'h0));
    tbl.push_back(mk(0, 0, 3'd0, 32'hC002, 64'h0, 64'h1122_3344, 0, ck, 32'hC000, 8'h0, 64'h0, 64'h1122_3344));
    tbl.push_back(mk(1, 0, 3'd6, 32'h104, 64'h0, 64'h8000_0000_0000_0001, 0, 0, 32'h100, 8'h0, 64'h0, 64'hFFFF_FFFF_8000_0000));
    tbl.push_back(mk(1, 0, 3'd5, 32'h100, 64'h0, 64'h8000_0000_0000_0001, 1, 0, 32'h100, 8'h0, 64'h0, 64'h1));
    tbl.push_back(mk(1, 1, 3'd6, 32'h204, 64'h0123_4567_89AB_CDEF, 64'h0, 0, 0, 32'h200, 8'hF0, 64'h89AB_CDEF_0000_0000, 64'h0));
    tbl.push_back(mk(1, 0, 3'd2, 32'h107, 64'h0, 64'h8000_0000_0000_0001, 0, 0, 32'h100, 8'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FF80));
    tbl.push_back(mk(1, 0, 3'd5, 32'h102, 64'h0, 64'h8000_0000_0000_0001, 0, ck, 32'h100, 8'h0, 64'h0, 64'h1));
    tbl.push_back(mk(1, 1, 3'd0, 32'h300, 64'hA5A5_5A5A_0F0F_F0F0, 64'h0, 2, 0, 32'h300, 8'hFF, 64'hA5A5_5A5A_0F0F_F0F0, 64'h0));
    tbl.push_back(mk(1, 0, 3'd4, 32'h10E, 64'h0, 64'h8000_0000_0000_0001, 0, 0, 32'h108, 8'h0, 64'h0, 64'hFFFF_FFFF_FFFF_8000));

    repeat (2) @(posedge clk);
    #1;
    chk("rst ready32", 64'(ready_32), 64'd1);
    chk("rst ready64", 64'(ready_64), 64'd1);
    chk("rst mreq", 64'({mreq_32, mreq_64}), 64'd0);
    chk("rst mwe", 64'({mwe_32, mwe_64}), 64'd0);
    chk("rst rvalid", 64'({rvalid_32, rvalid_64}), 64'd0);
    chk("rst rerr", 64'({rerr_32, rerr_64}), 64'd0);
    chk("rst busy", 64'({busy_32, busy_64}), 64'd0);
    chk("rst mbe", 64'({mbe_32, mbe_64}), 64'd0);
    chk("rst maddr", 64'(maddr_32 | maddr_64), 64'd0);
    chk("rst mwdata", mwdata_64 | 64'(mwdata_32), 64'd0);
    chk("rst rrdata", rrdata_64 | 64'(rrdata_32), 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    foreach (tbl[i]) run(tbl[i], $sformatf("vec%0d", i));

    // Reset during ACCESS aborts the access; acks seen afterwards are ignored.
    w64 = 1'b0; req_we = 1'b0; req_op = 3'd0; req_addr = 32'hD000; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("abort mreq_up", 64'(mreq_32), 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("abort mreq_async", 64'(mreq_32), 64'd0);
    chk("abort busy", 64'(busy_32), 64'd0);
    chk("abort ready", 64'(ready_32), 64'd1);
    mem_ack = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("idle_ack no_rsp", 64'(rvalid_32), 64'd0);
      chk("idle_ack no_mreq", 64'(mreq_32), 64'd0);
    end
    mem_ack = 1'b0;
    run(mk(0, 0, 3'd1, 32'hE001, 64'h0, 64'h0000_7F00, 0, 0, 32'hE000, 8'h0, 64'h0, 64'h7F), "post_reset");

    for (int i = 0; i < 150; i++) begin
      v.w64   = 1'($urandom_range(0, 1));
      v.we    = 1'($urandom_range(0, 1));
      v.op    = 3'($urandom_range(0, 7));
      v.addr  = $urandom;
      v.wdata = {$urandom, $urandom};
      v.rdata = {$urandom, $urandom};
      v.dly   = $urandom_range(0, 3);
      v.e     = model(v.w64, v.we, v.op, v.addr, v.wdata, v.rdata);
      run(v, $sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
